// File: rtl/axi_lite_slave_mem_if.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_mem_if
// AXI-Lite bus bundle between a master and the scratch-memory responder.
// Signals:
//   AW: awaddr[31:0], awvalid, awready
//   W : wdata[31:0], wstrb[3:0], wvalid, wready
//   B : bresp[1:0], bvalid, bready
//   AR: araddr[31:0], arvalid, arready
//   R : rdata[31:0], rresp[1:0], rvalid, rready
// Modports: master (drives requests), slave (drives readies/responses).
// ---------------------------------------------------------------------------
interface axi_lite_slave_mem_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_mem
// AXI-Lite responder backed by a word-addressed RAM of DEPTH_WORDS x 32 bits
// mapped at BASE_ADDR. Single-beat reads and writes; read and write channels
// run as independent FSMs sharing the one array.
// Ports:
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset (memory contents are kept)
//   axi_lite : AXI-Lite bus, slave modport
// Out-of-range accesses answer SLVERR (2'b10); reads of them return 0.
// ---------------------------------------------------------------------------
module axi_lite_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_lite_slave_mem_if.slave  axi_lite
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_beat_t;

  logic [31:0] mem [DEPTH_WORDS];

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_e    w_state, w_state_nxt;
  logic [31:0] aw_addr_q;
  w_beat_t     w_beat_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic        awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]  bresp_nxt;

  logic        aw_hs, w_hs;
  logic        wr_commit;
  logic [31:0] cm_addr;
  w_beat_t     cm_beat;
  logic [31:0] wr_off;
  logic        wr_in_range;
  logic [IW-1:0] wr_idx;
  logic        wr_en;

  assign aw_hs = axi_lite.awvalid & awready_q;
  assign w_hs  = axi_lite.wvalid & wready_q;

  // Unsigned offset: addresses below BASE_ADDR wrap to huge values and fall
  // out of range along with those above the window.
  assign wr_off      = cm_addr - BASE_ADDR;
  assign wr_in_range = wr_off < SPAN;
  assign wr_idx      = wr_off[IW+1:2];
  assign wr_en       = wr_commit & wr_in_range;

  always_comb begin
    w_state_nxt  = w_state;
    wr_commit    = 1'b0;
    cm_addr      = axi_lite.awaddr;
    cm_beat.data = axi_lite.wdata;
    cm_beat.strb = axi_lite.wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit   = 1'b1;
          w_state_nxt = W_RESP;
        end else if (aw_hs) begin
          w_state_nxt = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_state_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        cm_addr = aw_addr_q;
        if (w_hs) begin
          wr_commit   = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        cm_beat = w_beat_q;
        if (aw_hs) begin
          wr_commit   = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        // bvalid is always high here, so bready alone completes B.
        if (axi_lite.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase

    // Outputs are registered from the next state so they are 0 in reset and
    // come up on the first edge after release.
    awready_nxt = (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_DATA);
    wready_nxt  = (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_ADDR);
    bvalid_nxt  = (w_state_nxt == W_RESP);
    bresp_nxt   = (w_state_nxt == W_RESP) ? bresp_q : RESP_OKAY;
    if (wr_commit) bresp_nxt = wr_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_beat_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_nxt;
      awready_q <= awready_nxt;
      wready_q  <= wready_nxt;
      bvalid_q  <= bvalid_nxt;
      bresp_q   <= bresp_nxt;
      if (aw_hs) aw_addr_q <= axi_lite.awaddr;
      if (w_hs) begin
        w_beat_q.data <= axi_lite.wdata;
        w_beat_q.strb <= axi_lite.wstrb;
      end
    end
  end

  // Memory array: no reset. A commit needs a handshake, and readies are low
  // throughout reset, so nothing is written while rst_n is asserted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (cm_beat.strb[b]) mem[wr_idx][8*b +: 8] <= cm_beat.data[8*b +: 8];
      end
    end
  end

  assign axi_lite.awready = awready_q;
  assign axi_lite.wready  = wready_q;
  assign axi_lite.bvalid  = bvalid_q;
  assign axi_lite.bresp   = bresp_q;

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_e    r_state, r_state_nxt;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        ar_hs;
  logic [31:0] rd_off;
  logic        rd_in_range;
  logic [IW-1:0] rd_idx;

  assign ar_hs       = axi_lite.arvalid & arready_q;
  assign rd_off      = axi_lite.araddr - BASE_ADDR;
  assign rd_in_range = rd_off < SPAN;
  assign rd_idx      = rd_off[IW+1:2];

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (axi_lite.rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // rdata samples the array with a non-blocking read on the AR edge, so a
  // write committing to the same word on that edge is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state   <= r_state_nxt;
      arready_q <= (r_state_nxt == R_IDLE);
      rvalid_q  <= (r_state_nxt == R_DATA);
      if (ar_hs) begin
        rdata_q <= rd_in_range ? mem[rd_idx] : 32'h0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign axi_lite.arready = arready_q;
  assign axi_lite.rvalid  = rvalid_q;
  assign axi_lite.rdata   = rdata_q;
  assign axi_lite.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
module tb_axi_lite_slave_mem;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_slave_mem_if axi();

  axi_lite_slave_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .axi_lite(axi)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [DEPTH];

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " awready"}, axi.awready, 0);
    chk({tag, " wready"},  axi.wready,  0);
    chk({tag, " bvalid"},  axi.bvalid,  0);
    chk({tag, " bresp"},   axi.bresp,   0);
    chk({tag, " arready"}, axi.arready, 0);
    chk({tag, " rvalid"},  axi.rvalid,  0);
    chk({tag, " rdata"},   axi.rdata,   0);
    chk({tag, " rresp"},   axi.rresp,   0);
  endtask

  // AW and W together, bready held high.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    logic ok;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (axi.awready && axi.wready) ok = 1'b1;
      tick();
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk({tag, " aw/w accepted"}, ok, 1);
    chk({tag, " bvalid"}, axi.bvalid, 1);
    chk({tag, " bresp"}, axi.bresp, exp_resp);
    tick();
    chk({tag, " bvalid cleared"}, axi.bvalid, 0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp, input string tag);
    logic ok;
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (axi.arready) ok = 1'b1;
      tick();
    end
    axi.arvalid = 1'b0;
    chk({tag, " ar accepted"}, ok, 1);
    chk({tag, " rvalid"}, axi.rvalid, 1);
    chk({tag, " rdata"}, axi.rdata, exp_data);
    chk({tag, " rresp"}, axi.rresp, exp_resp);
    tick();
    chk({tag, " rvalid cleared"}, axi.rvalid, 0);
  endtask

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.wvalid = 1'b0; axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    #1 rst_n = 1'b1;
    #1 chk("release awready before edge", axi.awready, 0);
    tick();
    chk("post-reset awready", axi.awready, 1);
    chk("post-reset wready",  axi.wready,  1);
    chk("post-reset arready", axi.arready, 1);

    // Fill memory with a known pattern
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 32'hA500_0000 | 32'(i);
      wr(BASE + 32'(4 * i), exp_mem[i], 4'hF, 2'b00, "fill");
    end

    // 1: same-cycle AW/W, then read back
    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, "t1 wr");
    exp_mem[4] = 32'hDEAD_BEEF;
    rd(BASE + 32'h10, 32'hDEAD_BEEF, 2'b00, "t1 rd");

    // 2: W leads AW by 3 cycles, partial strobe
    axi.wdata = 32'h0000_1234; axi.wstrb = 4'b0011; axi.wvalid = 1'b1; axi.bready = 1'b1;
    chk("t2 wready before", axi.wready, 1);
    tick();
    axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      chk("t2 wready held low", axi.wready, 0);
      chk("t2 awready open", axi.awready, 1);
      chk("t2 no bvalid", axi.bvalid, 0);
      tick();
    end
    axi.awaddr = BASE + 32'h10; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    chk("t2 bvalid", axi.bvalid, 1);
    chk("t2 bresp", axi.bresp, 2'b00);
    tick();
    chk("t2 bvalid cleared", axi.bvalid, 0);
    exp_mem[4] = 32'hDEAD_1234;
    rd(BASE + 32'h10, 32'hDEAD_1234, 2'b00, "t2 rd");

    // 3: B backpressure, next write waits for B handshake
    axi.awaddr = BASE + 32'h14; axi.awvalid = 1'b1;
    axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    tick();
    axi.awaddr = BASE + 32'h18; axi.wdata = 32'h600D_600D;
    for (int i = 0; i < 5; i++) begin
      chk("t3 bvalid held", axi.bvalid, 1);
      chk("t3 bresp held", axi.bresp, 2'b00);
      chk("t3 awready low", axi.awready, 0);
      chk("t3 wready low", axi.wready, 0);
      tick();
    end
    axi.bready = 1'b1;
    tick();
    chk("t3 bvalid after B", axi.bvalid, 0);
    chk("t3 awready after B", axi.awready, 1);
    chk("t3 wready after B", axi.wready, 1);
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("t3 second bvalid", axi.bvalid, 1);
    chk("t3 second bresp", axi.bresp, 2'b00);
    tick();
    exp_mem[5] = 32'h0BAD_F00D;
    exp_mem[6] = 32'h600D_600D;
    rd(BASE + 32'h14, 32'h0BAD_F00D, 2'b00, "t3 rd w5");
    rd(BASE + 32'h18, 32'h600D_600D, 2'b00, "t3 rd w6");
    // R backpressure
    axi.araddr = BASE + 32'h10; axi.arvalid = 1'b1; axi.rready = 1'b0;
    tick();
    axi.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3 rvalid held", axi.rvalid, 1);
      chk("t3 rdata held", axi.rdata, 32'hDEAD_1234);
      chk("t3 rresp held", axi.rresp, 2'b00);
      chk("t3 arready low", axi.arready, 0);
      tick();
    end
    axi.rready = 1'b1;
    tick();
    chk("t3 rvalid after R", axi.rvalid, 0);
    chk("t3 arready after R", axi.arready, 1);

    // 4: range boundaries, wstrb=0, ignored addr[1:0]
    wr(BASE + 32'h100, 32'h5555_AAAA, 4'hF, 2'b10, "t4 wr above");
    rd(BASE + 32'h100, 32'h0, 2'b10, "t4 rd above");
    wr(BASE - 32'h4, 32'h5555_AAAA, 4'hF, 2'b10, "t4 wr below");
    rd(BASE - 32'h4, 32'h0, 2'b10, "t4 rd below");
    wr(BASE + 32'hFC, 32'hCAFE_F00D, 4'hF, 2'b00, "t4 wr last");
    exp_mem[63] = 32'hCAFE_F00D;
    wr(BASE + 32'h1C, 32'hFFFF_FFFF, 4'h0, 2'b00, "t4 wr nostrb");
    wr(BASE + 32'h23, 32'h7788_0000, 4'b1100, 2'b00, "t4 wr unaligned");
    exp_mem[8] = 32'h7788_0008;
    rd(BASE + 32'h22, 32'h7788_0008, 2'b00, "t4 rd unaligned");

    // 5: read/write collision on word 0x20
    wr(BASE + 32'h80, 32'h1111_1111, 4'hF, 2'b00, "t5 wr old");
    axi.araddr = BASE + 32'h80; axi.arvalid = 1'b1; axi.rready = 1'b1;
    axi.awaddr = BASE + 32'h80; axi.awvalid = 1'b1;
    axi.wdata = 32'h2222_2222; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b1;
    tick();
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("t5 rvalid", axi.rvalid, 1);
    chk("t5 rdata old", axi.rdata, 32'h1111_1111);
    chk("t5 bvalid", axi.bvalid, 1);
    chk("t5 bresp", axi.bresp, 2'b00);
    tick();
    exp_mem[32] = 32'h2222_2222;
    rd(BASE + 32'h80, 32'h2222_2222, 2'b00, "t5 rd new");

    // 6: reset with B and R pending
    axi.awaddr = BASE + 32'h24; axi.awvalid = 1'b1;
    axi.wdata = 32'h9999_9999; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    axi.araddr = BASE; axi.arvalid = 1'b1; axi.rready = 1'b0;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    exp_mem[9] = 32'h9999_9999;
    chk("t6 bvalid pending", axi.bvalid, 1);
    chk("t6 rvalid pending", axi.rvalid, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6 async reset");
    tick();
    #3 rst_n = 1'b1;
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    chk("t6 awready", axi.awready, 1);
    chk("t6 wready", axi.wready, 1);
    chk("t6 arready", axi.arready, 1);
    chk("t6 no stale bvalid", axi.bvalid, 0);
    chk("t6 no stale rvalid", axi.rvalid, 0);
    tick();
    chk("t6 bvalid still low", axi.bvalid, 0);
    chk("t6 rvalid still low", axi.rvalid, 0);
    // Half-done write (AW only) dropped by reset
    axi.awaddr = BASE + 32'h28; axi.awvalid = 1'b1;
    axi.wdata = 32'hFFFF_FFFF; axi.wstrb = 4'hF;
    tick();
    axi.awvalid = 1'b0;
    chk("t6 have-addr awready", axi.awready, 0);
    chk("t6 have-addr wready", axi.wready, 1);
    #2 rst_n = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("t6 awready after drop", axi.awready, 1);
    rd(BASE + 32'h28, 32'hA500_000A, 2'b00, "t6 rd dropped");

    // Full sweep against the model
    for (int i = 0; i < DEPTH; i++)
      rd(BASE + 32'(4 * i), exp_mem[i], 2'b00, "sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
AXI-Lite responder (subordinate) backed by a word-addressed RAM. It sits on the AXI-Lite bus opposite a master, such as the no-cache CPU path, and serves its single-beat reads and writes. It is used as the testbench/SoC scratch memory and as the target for checking the master end. Read and write channels are independent state machines sharing one memory array.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
axi_lite_awaddr  in  32  write address
axi_lite_awvalid  in  1  write address valid
axi_lite_awready  out  1  write address ready
axi_lite_wdata  in  32  write data
axi_lite_wstrb  in  4  byte strobes; bit i enables wdata[8i+7:8i]
axi_lite_wvalid  in  1  write data valid
axi_lite_wready  out  1  write data ready
axi_lite_bresp  out  2  write response
axi_lite_bvalid  out  1  write response valid
axi_lite_bready  in  1  write response ready
axi_lite_araddr  in  32  read address
axi_lite_arvalid  in  1  read address valid
axi_lite_arready  out  1  read address ready
axi_lite_rdata  out  32  read data
axi_lite_rresp  out  2  read response
axi_lite_rvalid  out  1  read data valid
axi_lite_rready  in  1  read data ready

Behaviour:
- Single clock clk. Reset rst_n is asynchronous, active-low. While rst_n=0, every output is 0: readies, bvalid, rvalid, bresp, rresp, rdata. Memory contents are not reset.
- All outputs are registered. Readies rise on the first clk edge after rst_n deasserts.
- A handshake completes on a rising edge where valid=1 and ready=1.
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Word index = (addr-BASE_ADDR)>>2. addr[1:0] is ignored.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_ADDR: awready=0, wready=1.
  - W_HAVE_DATA: awready=1, wready=0.
  - W_RESP: awready=0, wready=0, bvalid=1.
- Write transitions:
  - W_IDLE with AW and W in the same cycle -> commit the write and go to W_RESP.
  - W_IDLE with AW only -> latch address, go to W_HAVE_ADDR.
  - W_IDLE with W only -> latch data and strobes, go to W_HAVE_DATA.
  - W_HAVE_ADDR/W_HAVE_DATA on the missing handshake -> commit, go to W_RESP.
  - W_RESP: hold bvalid and bresp stable until bready=1, then go to W_IDLE. The next AW/W can be accepted no earlier than the cycle after the B handshake.
- Write commit (the edge on which both halves are held):
  - In range: only the strobed bytes update; bresp=2'b00 (OKAY). wstrb=0 writes nothing and still returns OKAY.
  - Out of range: memory is unchanged; bresp=2'b10 (SLVERR).
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: arready=0, rvalid=1.
- Read transitions:
  - R_IDLE on AR handshake: the memory word is read on that edge; rdata and rresp are registered; go to R_DATA. rvalid rises on the next edge, so latency is 1 cycle from AR handshake to rvalid.
  - Out-of-range read: rdata=0, rresp=2'b10.
  - R_DATA: hold rdata, rresp and rvalid stable until rready=1, then go to R_IDLE with rvalid=0. Back-to-back reads therefore take a minimum of 2 cycles each.
- Read/write collision: if an AR handshake and a write commit hit the same word on the same edge, rdata returns the OLD word (read-before-write). A later read sees the new value.
- Read and write channels progress fully concurrently; neither stalls the other.
- Reset asserted mid-transaction: all in-flight state is dropped and both FSMs go to IDLE. No response is issued for dropped transactions. A write that has not reached commit does not modify memory.

Test Plan:
1. Write to BASE+0x10 with AW and W in the same cycle, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid one cycle after the handshake, bresp=00. Then read 0x10 -> rvalid one cycle after AR, rdata=0xDEADBEEF, rresp=00.
2. Drive W (wdata=0x00001234, wstrb=4'b0011) 3 cycles before AW to the same address -> wready drops after the W handshake; commit happens on the AW edge. A later read returns 0xDEAD1234.
3. Hold bready=0 for 5 cycles after a write -> bvalid=1 and bresp stable throughout; awready=wready=0 throughout; the next write is accepted only after the B handshake. Repeat with rready=0 on a read -> rdata/rresp held, arready=0.
4. Write 0x5555AAAA to BASE+4*DEPTH_WORDS -> bresp=10 and all memory words unchanged. Read the same address -> rresp=10, rdata=0.
5. Read and write to word 0x20 on the same edge (old value 0x11111111, new value 0x22222222) -> read returns 0x11111111; the next read returns 0x22222222.
6. Pull rst_n low while bvalid=1 and rvalid=1 -> all outputs 0 immediately, without waiting for clk. After release, readies are 1 on the next edge and no stale bvalid/rvalid appears. A half-done write (AW only) leaves memory unchanged.
